// File: rtl/rca32_full_adder.sv
// One-bit full adder cell used as a link of the ripple-carry chain.
// Ports: a, b, cin (inputs); sum, cout (outputs).
module rca32_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/rca32_adder.sv
// WIDTH-bit ripple-carry adder with one registered output stage.
// Ports: clk, rst_n (async active-low), a, b, carryInput (inputs);
//        sum, carryOutput (registered outputs, {carryOutput,sum} = a+b+cin).
module rca32_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryInput,
    output logic [WIDTH-1:0] sum,
    output logic             carryOutput
);

    // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = carryInput;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        rca32_full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum         <= '0;
            carryOutput <= 1'b0;
        end else begin
            sum         <= sum_comb;
            carryOutput <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_rca32_adder.sv
// Directed-vector bench for rca32_adder.
// Ports: none; drives clk/rst_n/a/b/carryInput, checks sum/carryOutput.
module tb_rca32_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        carryInput;
    logic [31:0] sum;
    logic        carryOutput;

    int compared;
    int mismatched;

    rca32_adder #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .carryInput  (carryInput),
        .sum         (sum),
        .carryOutput (carryOutput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] exp);
        logic [32:0] obs;
        obs = {carryOutput, sum};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed co=%0d sum=%0d, expected co=%0d sum=%0d",
                   tag, obs[32], obs[31:0], exp[32], exp[31:0]);
        end
    endtask

    // apply operands, clock once, sample 1 time unit after the edge
    task automatic step(input string tag, input logic [31:0] va,
                        input logic [31:0] vb, input logic vc,
                        input logic [32:0] exp);
        a          = va;
        b          = vb;
        carryInput = vc;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        a          = 32'd0;
        b          = 32'd0;
        carryInput = 1'b0;

        #2;
        check("reset_initial", 33'd0);
        step("reset_hold", 32'd5, 32'd7, 1'b0, 33'd0);
        rst_n = 1'b1;
        step("reset_release", 32'd5, 32'd7, 1'b0, 33'd12);

        step("dir0", 32'd2212768, 32'd3612427, 1'b0, 33'd5825195);
        step("dir1", 32'd23632145, 32'd29946753, 1'b0, 33'd53578898);
        step("dir2", 32'd1915427, 32'd9538849, 1'b0, 33'd11454276);
        step("dir3", 32'd32768, 32'd32768, 1'b0, 33'd65536);
        step("dir4", 32'd45633827, 32'd22390374, 1'b0, 33'd68024201);
        step("dir5", 32'd655355467, 32'd655354378, 1'b0,
             33'd1310709845);

        step("cin", 32'd4519087, 32'd326432, 1'b1, 33'd4845520);

        step("ovf_cin0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
             {1'b1, 32'hFFFF_FFFE});
        step("ovf_cin1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
             {1'b1, 32'hFFFF_FFFF});
        step("ripple", 32'hFFFF_FFFF, 32'd0, 1'b1, {1'b1, 32'd0});
        step("zero", 32'd0, 32'd0, 1'b0, 33'd0);

        step("pre_async", 32'hFFFF_FFFF, 32'd1, 1'b1, {1'b1, 32'd1});
        rst_n = 1'b0;
        #1;
        check("async_clear", 33'd0);
        @(posedge clk);
        #1;
        check("async_hold", 33'd0);
        rst_n = 1'b1;
        step("resume", 32'd100, 32'd23, 1'b1, 33'd124);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
